// File: rtl/opl_sdm_dac.sv
// opl_sdm_dac: OPL2 output stage. A saturating x2 gain with mute feeds a
// linear interpolator that ramps between successive samples; the result drives
// a second-order sigma-delta modulator whose bit is replicated onto 7 pads.
module opl_sdm_dac #(
  parameter int unsigned INTERP_SHIFT = 4,
  parameter int unsigned INT_W        = 24
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic [15:0] snd_in,
  input  logic        snd_valid,
  input  logic        mute,
  output logic [15:0] level,
  output logic        busy,
  output logic        dac_out,
  output logic [6:0]  dac_pins
);

  typedef enum logic {S_IDLE, S_RAMP} state_t;

  localparam int unsigned       MW       = INT_W + 2;
  localparam logic [8:0]        CNT_INIT = 9'((1 << INTERP_SHIFT) - 1);
  localparam logic signed [17:0] LVL_MAX = 18'sd32767;
  localparam logic signed [17:0] LVL_MIN = -18'sd32768;
  localparam logic signed [MW-1:0] LIM_P = MW'(2 ** (INT_W - 2));
  localparam logic signed [MW-1:0] LIM_N = -LIM_P;
  localparam logic signed [MW-1:0] FB_P  = MW'(32767);
  localparam logic signed [MW-1:0] FB_N  = -MW'(32768);

  state_t                    r_state, w_state_nxt;
  logic signed [15:0]        r_level, w_level_nxt;
  logic signed [15:0]        r_target, w_target_nxt;
  logic signed [16:0]        r_step, w_step_nxt;
  logic [8:0]                r_cnt, w_cnt_nxt;
  logic signed [INT_W-1:0]   r_i1, r_i2, w_i1_nxt, w_i2_nxt;
  logic                      r_dac;

  logic signed [16:0]        w_g17;
  logic signed [15:0]        w_gain;
  logic signed [16:0]        w_diff;
  logic signed [17:0]        w_sum;
  logic signed [15:0]        w_sum_sat;
  logic signed [MW-1:0]      w_lvl_x, w_i1_x, w_i2_x, w_fb, w_s1, w_s2;

  // Gain: x2 in 17 bits, clamp to 16-bit range, force zero when muted.
  always_comb begin
    w_g17 = {snd_in, 1'b0};
    if (w_g17[16] != w_g17[15])
      w_gain = w_g17[16] ? 16'sh8000 : 16'sh7FFF;
    else
      w_gain = w_g17[15:0];
    if (mute)
      w_gain = '0;
    w_diff = {w_gain[15], w_gain} - {r_level[15], r_level};
    w_sum  = {{2{r_level[15]}}, r_level} + {r_step[16], r_step};
    if (w_sum > LVL_MAX)
      w_sum_sat = 16'sh7FFF;
    else if (w_sum < LVL_MIN)
      w_sum_sat = 16'sh8000;
    else
      w_sum_sat = w_sum[15:0];
  end

  // Interpolator next-state: a strobe always restarts the ramp from the current level.
  always_comb begin
    w_state_nxt  = r_state;
    w_level_nxt  = r_level;
    w_target_nxt = r_target;
    w_step_nxt   = r_step;
    w_cnt_nxt    = r_cnt;
    if (snd_valid) begin
      w_target_nxt = w_gain;
      w_step_nxt   = w_diff >>> INTERP_SHIFT;
      w_cnt_nxt    = CNT_INIT;
      w_state_nxt  = S_RAMP;
    end else if (r_state == S_RAMP) begin
      if (r_cnt != '0) begin
        w_level_nxt = w_sum_sat;
        w_cnt_nxt   = r_cnt - 9'd1;
      end else begin
        // last cycle lands exactly on target, discarding accumulated step truncation
        w_level_nxt = r_target;
        w_state_nxt = S_IDLE;
      end
    end
  end

  // Interpolator registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state  <= S_IDLE;
      r_level  <= '0;
      r_target <= '0;
      r_step   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_level  <= w_level_nxt;
      r_target <= w_target_nxt;
      r_step   <= w_step_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Modulator sums in a widened domain, then clamped to +/-2^(INT_W-2).
  always_comb begin
    w_lvl_x = {{(MW-16){r_level[15]}}, r_level};
    w_i1_x  = {{2{r_i1[INT_W-1]}}, r_i1};
    w_i2_x  = {{2{r_i2[INT_W-1]}}, r_i2};
    w_fb    = r_dac ? FB_P : FB_N;
    w_s1    = w_i1_x + w_lvl_x - w_fb;
    w_s2    = w_i2_x + w_i1_x - w_fb;
    if (w_s1 > LIM_P)      w_i1_nxt = LIM_P[INT_W-1:0];
    else if (w_s1 < LIM_N) w_i1_nxt = LIM_N[INT_W-1:0];
    else                   w_i1_nxt = w_s1[INT_W-1:0];
    if (w_s2 > LIM_P)      w_i2_nxt = LIM_P[INT_W-1:0];
    else if (w_s2 < LIM_N) w_i2_nxt = LIM_N[INT_W-1:0];
    else                   w_i2_nxt = w_s2[INT_W-1:0];
  end

  // Modulator registers; the output bit comes from the unsaturated second sum.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_dac <= 1'b0;
    end else begin
      r_i1  <= w_i1_nxt;
      r_i2  <= w_i2_nxt;
      r_dac <= ~w_s2[MW-1];
    end
  end

  assign level    = r_level;
  assign busy     = (r_state == S_RAMP);
  assign dac_out  = r_dac;
  assign dac_pins = {7{r_dac}};

endmodule

// File: doc/opl_sdm_dac.md
Name: opl_sdm_dac

Overview:
- Output stage that consumes the signed 16-bit sample stream from the OPL2 core and its per-sample strobe.
- Applies a saturating ×2 gain and a mute.
- Linearly interpolates between successive samples.
- Drives a second-order sigma-delta modulator that produces the 1-bit audio stream replicated onto the 7 audio pads.
- Sits between the OPL2 instance and the board audio pins, and replaces the first-order modulator in the sound block.

Parameters:
- INTERP_SHIFT, 4: ramp length is 2^INTERP_SHIFT clocks per sample. Legal range is 0..8.
- INT_W, 24: width of each sigma-delta integrator, signed.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_l  in  1  asynchronous, active-low reset.
- snd_in  in  16  signed two's-complement sample from the OPL2 core.
- snd_valid  in  1  one-cycle strobe; snd_in is valid in that cycle.
- mute  in  1  when 1, captured samples are replaced by 0.
- level  out  16  signed current interpolated level fed to the modulator.
- busy  out  1  1 while a ramp is in progress.
- dac_out  out  1  modulator bit.
- dac_pins  out  7  dac_out replicated on all 7 bits.

Behaviour:
- Reset: reset_l low asynchronously clears all state. Reset values:
  - level = 0, busy = 0, dac_out = 0, dac_pins = 0.
  - Integrators = 0, ramp counter = 0, target = 0, step = 0, state IDLE.
- Reset asserted mid-ramp aborts the ramp. The first strobe after release ramps from 0.
- Gain stage (combinational, on snd_in):
  - g = snd_in sign-extended to 17 bits, then shifted left by 1.
  - If g > 32767, g = 0x7FFF. If g < -32768, g = 0x8000.
  - If mute = 1 in the strobe cycle, g = 0.
- State machine, two states IDLE and RAMP:
  - Capture in any state: snd_valid=1 sets target <= g.
  - Capture also sets step <= (g - level), computed in 17-bit signed, then arithmetic-shifted right by INTERP_SHIFT.
  - Capture sets cnt <= 2^INTERP_SHIFT - 1 and moves to RAMP.
  - RAMP, cnt != 0: level <= level + step, cnt <= cnt - 1.
  - RAMP, cnt == 0: level <= target exactly (absorbs truncation error), go to IDLE.
  - A snd_valid arriving during RAMP restarts the ramp from the current level. No sample is dropped; the newest sample wins.
  - The capture cycle does not itself update level.
- Ramp timing: the first level update is 1 cycle after the strobe. level == target 2^INTERP_SHIFT cycles after the strobe.
- INTERP_SHIFT = 0: level == target 1 cycle after the strobe.
- busy = (state == RAMP).
- level must never leave [-32768, 32767]. Intermediate additions use 17 bits and saturate.
- Modulator, every clk cycle:
  - fb = +32767 if dac_out = 1, else -32768.
  - i1 <= sat(i1 + level - fb).
  - i2 <= sat(i2 + i1 - fb), where i1 is the registered (old) value.
  - dac_out <= (i2 + i1 - fb >= 0), using the same unsaturated sum.
  - sat clamps to ±(2^(INT_W-2)) and prevents wrap on full-scale input.
- Long-run density of ones = (level + 32768) / 65535.
- dac_pins = {7{dac_out}}, registered together with dac_out.
- Sample rate: no timeout. level holds the last target indefinitely if snd_valid stops.

Test Plan:
1. Reset mid-ramp:
   - Stimulus: INTERP_SHIFT=4; snd_in=0x3000 strobe; drop reset_l asynchronously 5 cycles later, between clock edges.
   - Required: level=0, busy=0, dac_pins=0 immediately, before the next edge.
   - After release, a strobe of 0x1000 ramps from 0 to 0x2000.
2. Gain and ramp:
   - Stimulus: from level 0, snd_in=0x3000 strobe.
   - Required: step=0x0600; level=0x0600 at +1 and 0x3000 at +8; level=0x6000 exactly at +16; busy falls at +16.
3. Saturation:
   - snd_in=0x4000 gives target 0x7FFF.
   - snd_in=0xB000 gives target 0x8000.
   - Stepping 0x8000→0x7FFF ends at exactly 0x7FFF with no wrap.
4. Restart:
   - Stimulus: strobe 0x3000, then strobe 0x0000 at +6 (level=0x2400).
   - Required: new step=0xFDC0; level reaches 0x0000 exactly 16 cycles after the second strobe; busy held high continuously.
5. Mute:
   - mute=1 with a strobe of 0x2000 gives target 0 and level ramps to 0.
   - mute toggled with no strobe leaves level unchanged.
6. Modulator density:
   - Stimulus: hold level=0x2000 (strobe snd_in=0x1000), then count dac_out ones over 4096 cycles after 256 settle cycles.
   - Required: 2560 ±8 ones.
   - level=0x7FFF gives ≥4090 ones; level=0x8000 gives ≤6 ones; integrators never wrap.
